// File: rtl/aes_ctr_driver_pkg.sv
// Shared types and constants for the AES-CTR stream driver and its output buffer.
package aes_ctr_driver_pkg;

    // Key width of the aes_ctr build this driver is paired with.
    localparam int DEFAULT_KEY_SIZE = 128;
    localparam int BLOCK_W          = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_IV,
        ST_STREAM,
        ST_DRAIN
    } drv_state_t;

    typedef struct packed {
        logic               last;
        logic [BLOCK_W-1:0] data;
    } obuf_entry_t;

endpackage

// File: rtl/aes_ctr_obuf.sv
// Synchronous FIFO absorbing engine output blocks; exposes its head entry and occupancy.
module aes_ctr_obuf
    import aes_ctr_driver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  obuf_entry_t              push_data,
    input  logic                     pop,
    output obuf_entry_t              head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    obuf_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/aes_ctr_driver.sv
// Sequences key/IV load and block issue into aes_ctr, buffering its unstoppable output
// behind a credit check so the downstream stream may apply backpressure.
module aes_ctr_driver
    import aes_ctr_driver_pkg::*;
#(
    parameter int KEY_SIZE   = DEFAULT_KEY_SIZE,
    parameter int OBUF_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start_i,
    input  logic                cfg_new_key_i,
    input  logic [KEY_SIZE-1:0] cfg_key_i,
    input  logic [127:0]        cfg_iv_i,
    output logic                cfg_ready_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    input  logic [127:0]        s_data_i,
    input  logic                s_valid_i,
    input  logic                s_last_i,
    output logic                s_ready_o,
    output logic [127:0]        m_data_o,
    output logic                m_valid_o,
    output logic                m_last_o,
    input  logic                m_ready_i,
    output logic [KEY_SIZE-1:0] key_o,
    output logic                key_valid_o,
    input  logic                key_ready_i,
    output logic [127:0]        iv_o,
    output logic                iv_valid_o,
    output logic [127:0]        din_o,
    output logic                din_valid_o,
    input  logic                din_ready_i,
    input  logic [127:0]        dout_i,
    input  logic                dout_valid_i
);

    localparam int CW = $clog2(OBUF_DEPTH) + 1;

    drv_state_t          state_reg, state_next;
    logic [KEY_SIZE-1:0] key_reg;
    logic [127:0]        iv_reg;
    logic                inflight_reg;
    logic                last_pend_reg;
    logic                err_reg;

    logic [CW-1:0]       count;
    logic [CW:0]         credit_sum;
    logic                credit_ok;
    logic                buf_empty;
    logic                buf_full;
    logic                start_accept;
    logic                accept;
    logic                push;
    logic                pop;
    logic                fault;
    obuf_entry_t         head;
    obuf_entry_t         push_entry;

    // Credit counts both stored blocks and the one still inside the engine pipeline.
    assign credit_sum   = {1'b0, count} + (CW+1)'(inflight_reg);
    assign credit_ok    = credit_sum < (CW+1)'(OBUF_DEPTH);
    assign start_accept = (state_reg == ST_IDLE) & cfg_start_i;
    assign accept       = s_valid_i & s_ready_o;
    assign push         = dout_valid_i & inflight_reg & ~buf_full;
    assign fault        = dout_valid_i & (~inflight_reg | buf_full);
    assign pop          = m_valid_o & m_ready_i;
    assign push_entry   = '{last: last_pend_reg, data: dout_i};

    assign cfg_ready_o = (state_reg == ST_IDLE);
    assign busy_o      = (state_reg != ST_IDLE);
    assign err_o       = err_reg;
    assign key_o       = key_reg;
    assign iv_o        = iv_reg;
    assign din_o       = s_data_i;
    assign din_valid_o = accept;
    assign m_valid_o   = ~buf_empty;
    assign m_data_o    = head.data;
    assign m_last_o    = head.last & ~buf_empty;

    always_comb begin
        state_next  = state_reg;
        key_valid_o = 1'b0;
        iv_valid_o  = 1'b0;
        s_ready_o   = 1'b0;
        done_o      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cfg_start_i) state_next = cfg_new_key_i ? ST_KEY : ST_IV;
            end
            ST_KEY: begin
                key_valid_o = key_ready_i;
                if (key_ready_i) state_next = ST_IV;
            end
            ST_IV: begin
                iv_valid_o = 1'b1;
                state_next = ST_STREAM;
            end
            ST_STREAM: begin
                s_ready_o = din_ready_i & credit_ok;
                if (s_valid_i && s_ready_o && s_last_i) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!inflight_reg && buf_empty) begin
                    done_o     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            key_reg       <= '0;
            iv_reg        <= '0;
            inflight_reg  <= 1'b0;
            last_pend_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_accept) begin
                key_reg <= cfg_key_i;
                iv_reg  <= cfg_iv_i;
            end
            // A new accept in the same cycle as a return keeps one block in flight.
            if (accept) begin
                inflight_reg  <= 1'b1;
                last_pend_reg <= s_last_i;
            end else if (dout_valid_i) begin
                inflight_reg  <= 1'b0;
            end
            if (fault)             err_reg <= 1'b1;
            else if (start_accept) err_reg <= 1'b0;
        end
    end

    aes_ctr_obuf #(
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .empty     (buf_empty),
        .full      (buf_full),
        .count     (count)
    );

endmodule

// File: tb/tb_aes_ctr_driver.sv
// Bench for aes_ctr_driver: a 1-cycle-latency CTR engine stand-in plus a message-level
// reference (expected block i = plaintext ^ keystream(key, IV + i)).
module tb_aes_ctr_driver;

    localparam logic [127:0] NK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] NIV = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] P0  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C0  = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] P1  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C1  = 128'h9806f66b7970fdff8617187bb9fffdff;
    localparam int BUDGET = 2000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_start = 1'b0, cfg_new_key = 1'b0;
    logic [127:0] cfg_key = '0, cfg_iv = '0;
    logic         cfg_ready, busy, done, err;
    logic [127:0] s_data = '0;
    logic         s_valid = 1'b0, s_last = 1'b0, s_ready;
    logic [127:0] m_data;
    logic         m_valid, m_last;
    logic         m_ready = 1'b0;
    logic [127:0] key_w, iv_w, din_w, dout_w;
    logic         key_valid, key_ready, iv_valid, din_valid, din_ready, dout_valid;

    int errors = 0;
    int checks = 0;
    int key_pulses = 0, iv_pulses = 0, din_issues = 0;
    bit rand_eng = 1'b0;
    bit inject = 1'b0;
    logic [127:0] eng_key, eng_ctr;
    logic [127:0] model_key = '0;
    logic [127:0] blk [16];
    logic [128:0] exp_q [$];

    aes_ctr_driver #(.KEY_SIZE(128), .OBUF_DEPTH(4)) dut (
        .clk (clk), .rst_n (rst_n),
        .cfg_start_i (cfg_start), .cfg_new_key_i (cfg_new_key),
        .cfg_key_i (cfg_key), .cfg_iv_i (cfg_iv), .cfg_ready_o (cfg_ready),
        .busy_o (busy), .done_o (done), .err_o (err),
        .s_data_i (s_data), .s_valid_i (s_valid), .s_last_i (s_last), .s_ready_o (s_ready),
        .m_data_o (m_data), .m_valid_o (m_valid), .m_last_o (m_last), .m_ready_i (m_ready),
        .key_o (key_w), .key_valid_o (key_valid), .key_ready_i (key_ready),
        .iv_o (iv_w), .iv_valid_o (iv_valid),
        .din_o (din_w), .din_valid_o (din_valid), .din_ready_i (din_ready),
        .dout_i (dout_w), .dout_valid_i (dout_valid)
    );

    always #5 clk = ~clk;

    // Keystream oracle: exact AES values for the two known-answer counters, a mix otherwise.
    function automatic logic [127:0] ks(input logic [127:0] k, input logic [127:0] c);
        if (k == NK && c == NIV)               return P0 ^ C0;
        if (k == NK && c == NIV + 128'd1)      return P1 ^ C1;
        return {c[63:0], c[127:64]} ^ k ^ (c * 128'h9e3779b97f4a7c15f39cc0605cedc835);
    endfunction

    // Engine stand-in: one-cycle latency, counter loaded by iv_valid.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_key    <= '0;
            eng_ctr    <= '0;
            dout_valid <= 1'b0;
            dout_w     <= '0;
        end else begin
            dout_valid <= (din_valid & din_ready) | inject;
            dout_w     <= din_w ^ ks(eng_key, eng_ctr);
            if (din_valid && din_ready) eng_ctr <= eng_ctr + 128'd1;
            if (iv_valid)               eng_ctr <= iv_w;
            if (key_valid && key_ready) eng_key <= key_w;
        end
    end

    always @(posedge clk) begin
        if (key_valid) key_pulses <= key_pulses + 1;
        if (iv_valid)  iv_pulses  <= iv_pulses + 1;
        if (din_valid && din_ready) din_issues <= din_issues + 1;
    end

    always @(negedge clk) begin
        din_ready = rand_eng ? ($urandom_range(0, 3) != 0) : 1'b1;
        key_ready = rand_eng ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic start_msg(input bit nk, input logic [127:0] k, input logic [127:0] iv, input int n);
        int t = 0;
        if (nk) model_key = k;
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == n - 1), blk[i] ^ ks(model_key, iv + 128'(i))});
        @(negedge clk);
        while (!cfg_ready && t < BUDGET) begin @(negedge clk); t++; end
        if (t >= BUDGET) timeout("cfg_ready_wait");
        cfg_start = 1'b1; cfg_new_key = nk; cfg_key = k; cfg_iv = iv;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("err_clear_on_start", 128'(err), 128'(0));
        chk("busy_after_start", 128'(busy), 128'(1));
    endtask

    task automatic send(input int n_send, input int n_total, input bit gaps);
        for (int i = 0; i < n_send; i++) begin
            int  t = 0;
            bit  acc = 1'b0;
            do begin
                @(negedge clk);
                s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                s_data  = blk[i];
                s_last  = (i == n_total - 1);
                #1;
                acc = s_valid && s_ready;
                t++;
            end while (!acc && t < BUDGET);
            if (!acc) begin timeout("s_ready_wait"); break; end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic recv(input int n, input bit rnd);
        int got = 0;
        int t = 0;
        logic [128:0] e;
        while (got < n && t < BUDGET) begin
            @(negedge clk);
            m_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (m_valid && m_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                $display("out %0d: data=%h last=%0b", got, m_data, m_last);
                chk("m_data", m_data, e[127:0]);
                chk("m_last", 128'(m_last), 128'(e[128]));
                got++;
            end
            t++;
        end
        if (got < n) timeout("m_valid_wait");
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < BUDGET) begin @(negedge clk); t++; end
        if (t >= BUDGET) begin timeout("done_wait"); return; end
        chk("err_after_msg", 128'(err), 128'(0));
        @(negedge clk);
        chk("done_single_pulse", 128'(done), 128'(0));
        chk("cfg_ready_after_done", 128'(cfg_ready), 128'(1));
    endtask

    task automatic run_msg(input bit nk, input logic [127:0] k, input logic [127:0] iv,
                           input int n, input bit rnd);
        start_msg(nk, k, iv, n);
        fork
            send(n, n, rnd);
            recv(n, rnd);
        join
        wait_done();
    endtask

    initial begin
        int k0, i0, d0, n;
        logic [127:0] rk, riv;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cfg_ready", 128'(cfg_ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_m_last", 128'(m_last), 128'(0));
        chk("rst_s_ready", 128'(s_ready), 128'(0));
        chk("rst_key_valid", 128'(key_valid), 128'(0));
        chk("rst_iv_valid", 128'(iv_valid), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_key_o", key_w, 128'(0));
        chk("rst_iv_o", iv_w, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Known-answer single block
        blk[0] = P0;
        k0 = key_pulses; i0 = iv_pulses;
        run_msg(1'b1, NK, NIV, 1, 1'b0);
        chk("kat1_key_pulses", 128'(key_pulses - k0), 128'(1));
        chk("kat1_iv_pulses", 128'(iv_pulses - i0), 128'(1));

        // Known-answer two blocks
        blk[0] = P0; blk[1] = P1;
        run_msg(1'b1, NK, NIV, 2, 1'b0);

        // Backpressure: output stalled for 50 cycles during a 10-block message
        for (int i = 0; i < 10; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
        start_msg(1'b0, NK, NIV, 10);
        d0 = din_issues;
        fork
            send(10, 10, 1'b0);
            begin
                repeat (50) @(negedge clk);
                #1;
                chk("bp_din_issues", 128'(din_issues - d0), 128'(4));
                chk("bp_s_ready_low", 128'(s_ready), 128'(0));
                recv(10, 1'b0);
            end
        join
        wait_done();

        // Key reuse with a fresh IV
        for (int i = 0; i < 5; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
        riv = {$urandom, $urandom, $urandom, $urandom};
        k0 = key_pulses; i0 = iv_pulses;
        run_msg(1'b0, 128'(0), riv, 5, 1'b0);
        chk("reuse_key_pulses", 128'(key_pulses - k0), 128'(0));
        chk("reuse_iv_pulses", 128'(iv_pulses - i0), 128'(1));

        // Randomized messages with engine and sink stalls
        rand_eng = 1'b1;
        for (int m = 0; m < 4; m++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
            rk  = {$urandom, $urandom, $urandom, $urandom};
            riv = {$urandom, $urandom, $urandom, $urandom};
            run_msg((m != 2), rk, riv, n, 1'b1);
        end
        rand_eng = 1'b0;

        // Protocol fault: engine output with nothing in flight
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        @(negedge clk);
        chk("fault_err_set", 128'(err), 128'(1));
        chk("fault_buf_unchanged", 128'(m_valid), 128'(0));
        repeat (5) @(negedge clk);
        chk("fault_err_sticky", 128'(err), 128'(1));
        blk[0] = {$urandom, $urandom, $urandom, $urandom};
        run_msg(1'b0, 128'(0), NIV, 1, 1'b0);

        // Reset in the middle of a message
        for (int i = 0; i < 6; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
        start_msg(1'b1, NK, NIV, 6);
        send(3, 6, 1'b0);
        repeat (2) @(negedge clk);
        chk("midrst_pre_m_valid", 128'(m_valid), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", 128'(m_valid), 128'(0));
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_cfg_ready", 128'(cfg_ready), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        blk[0] = P0;
        run_msg(1'b1, NK, NIV, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
